npc_lsu: RTL and testbench

// - NP-core load/store unit sitting directly upstream of the AXI master/arbiter (npm); drives its npc_* request port.
// - Accepts one DMA command at a time from the core sequencer and moves 64-bit words between DDR and a local on-chip buffer.
// - Load (rwn=1): DDR -> buffer. Store (rwn=0): buffer -> DDR.
// - Compute datapath reaches the same buffer through a local port while the unit is idle.

---
 rtl/npu_pkg.sv | 15 +
 rtl/npc_buf.sv | 39 +++
 rtl/npc_lsu.sv | 166 ++++++++++++++++
 tb/tb_npc_lsu.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NP-core types: load/store unit state encoding and DDR-side widths.
package npu_pkg;

  localparam int DATA_W    = 64;
  localparam int NPC_LEN_W = 32;
  localparam int NPC_ADR_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_XFER = 4'b0100,
    ST_DONE = 4'b1000
  } lsu_state_e;

endpackage

// File: rtl/npc_buf.sv
// Local word buffer: simple dual-port synchronous RAM, one write port and one
// registered read port.
module npc_buf
  import npu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     wadr,
  input  logic [DATA_W-1:0] wdt,
  input  logic              re,
  input  logic [AW-1:0]     radr,
  output logic [DATA_W-1:0] rdt
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdt_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wadr] <= wdt;
    end
  end

  // Read register is an output of the unit, so it joins the async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdt_q <= '0;
    end else if (re) begin
      rdt_q <= mem_q[radr];
    end
  end

  assign rdt = rdt_q;

endmodule

// File: rtl/npc_lsu.sv
// NP-core load/store unit: moves 64-bit words between DDR (through npm) and the
// local buffer, one command at a time; the compute side owns the buffer when idle.
module npc_lsu
  import npu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic                 cmd_rwn,
  input  logic [NPC_ADR_W-1:0] cmd_ext_adr,
  input  logic [AW-1:0]        cmd_loc_adr,
  input  logic [NPC_LEN_W-1:0] cmd_len,
  output logic                 done,
  output logic                 busy,
  input  logic                 loc_en,
  input  logic                 loc_we,
  input  logic [AW-1:0]        loc_adr,
  input  logic [DATA_W-1:0]    loc_wdt,
  output logic [DATA_W-1:0]    loc_rdt,
  output logic                 npc_req,
  input  logic                 npc_gnt,
  output logic                 npc_rwn,
  output logic [NPC_ADR_W-1:0] npc_adr,
  output logic [NPC_LEN_W-1:0] npc_len,
  output logic [DATA_W-1:0]    npc_wdt,
  input  logic [DATA_W-1:0]    npc_rdt,
  input  logic                 npc_ack
);

  lsu_state_e           state_q, state_d;
  logic                 rwn_q, rwn_d;
  logic [NPC_ADR_W-1:0] ext_q, ext_d;
  logic [NPC_LEN_W-1:0] len_q, len_d;
  logic [NPC_LEN_W-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 cmd_rdy_q, cmd_rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 req_q, req_d;

  logic                 accept;
  logic                 ack_x;
  logic                 buf_we, buf_re;
  logic [AW-1:0]        buf_wadr, buf_radr;
  logic [DATA_W-1:0]    buf_wdt, buf_rdt;

  always_comb begin
    state_d = state_q;
    rwn_d   = rwn_q;
    ext_d   = ext_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    ptr_d   = ptr_q;
    accept  = cmd_vld && cmd_rdy_q;
    ack_x   = (state_q == ST_XFER) && npc_ack;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rwn_d   = cmd_rwn;
          ext_d   = cmd_ext_adr;
          len_d   = cmd_len;
          ptr_d   = cmd_loc_adr;
          bcnt_d  = '0;
          state_d = (cmd_len == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (npc_gnt) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (npc_ack) begin
          bcnt_d = bcnt_q + 32'd1;
          ptr_d  = ptr_q + AW'(1);
          if (bcnt_q == len_q - 32'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // done is the registered image of DONE, so the command port stays closed
    // through the done cycle and reopens right after it.
    done_d    = (state_q == ST_DONE);
    cmd_rdy_d = (state_d == ST_IDLE) && (state_q != ST_DONE);
    busy_d    = !cmd_rdy_d;
    req_d     = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rwn_q     <= 1'b0;
      ext_q     <= '0;
      len_q     <= '0;
      bcnt_q    <= '0;
      ptr_q     <= '0;
      cmd_rdy_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rwn_q     <= rwn_d;
      ext_q     <= ext_d;
      len_q     <= len_d;
      bcnt_q    <= bcnt_d;
      ptr_q     <= ptr_d;
      cmd_rdy_q <= cmd_rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
    end
  end

  // Buffer port mux: DMA owns it while busy. Reading ptr in REQ preloads the
  // first store word; reading ptr+1 on an ack keeps back-to-back beats fed.
  always_comb begin
    if (busy_q) begin
      buf_we   = ack_x && rwn_q;
      buf_wadr = ptr_q;
      buf_wdt  = npc_rdt;
      buf_re   = 1'b1;
      buf_radr = ack_x ? ptr_q + AW'(1) : ptr_q;
    end else begin
      buf_we   = loc_en && loc_we;
      buf_wadr = loc_adr;
      buf_wdt  = loc_wdt;
      buf_re   = loc_en && !loc_we;
      buf_radr = loc_adr;
    end
  end

  npc_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk (clk),
    .rstn(rstn),
    .we  (buf_we),
    .wadr(buf_wadr),
    .wdt (buf_wdt),
    .re  (buf_re),
    .radr(buf_radr),
    .rdt (buf_rdt)
  );

  assign cmd_rdy = cmd_rdy_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign npc_req = req_q;
  assign npc_rwn = rwn_q;
  assign npc_adr = ext_q;
  assign npc_len = len_q;
  assign npc_wdt = buf_rdt;
  assign loc_rdt = buf_rdt;

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: stands in for npm plus a DDR word memory and checks the
// unit against a word-level buffer/DDR model.
module tb_npc_lsu;
  import npu_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DDR_W = 2048;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_vld, cmd_rdy, cmd_rwn;
  logic [31:0]       cmd_ext_adr, cmd_len;
  logic [AW-1:0]     cmd_loc_adr;
  logic              done, busy;
  logic              loc_en, loc_we;
  logic [AW-1:0]     loc_adr;
  logic [63:0]       loc_wdt, loc_rdt;
  logic              npc_req, npc_gnt, npc_rwn, npc_ack;
  logic [31:0]       npc_adr, npc_len;
  logic [63:0]       npc_wdt, npc_rdt;

  int errs = 0;
  int checks = 0;

  logic [63:0] m_buf [DEPTH];
  bit          m_vld [DEPTH];
  logic [63:0] ddr   [DDR_W];
  logic        m_rwn;
  logic [31:0] m_ext, m_len;
  int          m_loc;
  int          stall_pct;
  bit          npm_active;
  int          npm_beat;
  int          gnt_cnt, done_cnt, req_cyc;

  always #5 clk = ~clk;

  npc_lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_rwn(cmd_rwn),
    .cmd_ext_adr(cmd_ext_adr), .cmd_loc_adr(cmd_loc_adr), .cmd_len(cmd_len),
    .done(done), .busy(busy),
    .loc_en(loc_en), .loc_we(loc_we), .loc_adr(loc_adr),
    .loc_wdt(loc_wdt), .loc_rdt(loc_rdt),
    .npc_req(npc_req), .npc_gnt(npc_gnt), .npc_rwn(npc_rwn),
    .npc_adr(npc_adr), .npc_len(npc_len), .npc_wdt(npc_wdt),
    .npc_rdt(npc_rdt), .npc_ack(npc_ack)
  );

  function automatic logic [63:0] ddr_pat(input int i);
    logic [31:0] w;
    w = 32'(i);
    return {32'hDDD0_0000 + w, 32'h1234_0000 + w};
  endfunction

  function automatic logic [63:0] loc_pat(input int i);
    logic [31:0] w;
    w = 32'(i);
    return {32'hB0B0_0000 + w, 32'hC0C0_0000 + w};
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // npm + DDR stand-in: grants after a short random delay, then supplies or
  // absorbs len beats with random stalls and a short gap at each 256-beat burst.
  initial begin : npm
    int  n, base, gap;
    bit  go;
    logic rwn;
    npc_gnt = 1'b0; npc_ack = 1'b0; npc_rdt = '0;
    npm_active = 1'b0; npm_beat = 0;
    forever begin
      @(posedge clk); #1;
      if (rstn && npc_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (!rstn) continue;
        rwn  = npc_rwn;
        base = int'(npc_adr >> 3);
        n    = int'(npc_len);
        gnt_cnt++;
        npc_gnt = 1'b1;
        @(posedge clk); #1;
        npc_gnt = 1'b0;
        npm_active = 1'b1; npm_beat = 0; gap = 0;
        while (npm_beat < n && rstn) begin
          if (npm_beat != 0 && npm_beat % 256 == 0 && gap < 2) begin
            go = 1'b0;
            gap++;
          end else begin
            go = ($urandom_range(0, 99) >= stall_pct);
          end
          npc_ack = go;
          npc_rdt = (go && rwn) ? ddr[(base + npm_beat) % DDR_W] : '0;
          @(negedge clk);
          if (go && !rwn && rstn) ddr[(base + npm_beat) % DDR_W] = npc_wdt;
          @(posedge clk); #1;
          if (go) begin
            npm_beat++;
            gap = 0;
          end
        end
        npc_ack = 1'b0; npc_rdt = '0; npm_active = 1'b0;
      end
    end
  end

  // Per-cycle checks of handshake rules and store data against the model.
  initial begin : cmp
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk1("busy_vs_rdy", busy, !cmd_rdy);
        if (done) begin
          done_cnt++;
          chk1("done_while_busy", busy, 1'b1);
        end
        if (npc_req) begin
          req_cyc++;
          chk1("req_rwn", npc_rwn, m_rwn);
          chk64("req_adr", 64'(npc_adr), 64'(m_ext));
          chk64("req_len", 64'(npc_len), 64'(m_len));
        end
        if (npm_active && npc_ack && !m_rwn)
          chk64("store_wdt", npc_wdt, m_buf[(m_loc + npm_beat) % DEPTH]);
      end
    end
  end

  task automatic loc_write(input int adr, input logic [63:0] d, input bit applies);
    @(posedge clk); #1;
    loc_en = 1'b1; loc_we = 1'b1; loc_adr = AW'(adr); loc_wdt = d;
    @(posedge clk); #1;
    loc_en = 1'b0; loc_we = 1'b0;
    if (applies) begin
      m_buf[adr] = d;
      m_vld[adr] = 1'b1;
    end
  endtask

  task automatic loc_read(input int adr, output logic [63:0] d);
    @(posedge clk); #1;
    loc_en = 1'b1; loc_we = 1'b0; loc_adr = AW'(adr);
    @(posedge clk); #1;
    loc_en = 1'b0;
    @(negedge clk);
    d = loc_rdt;
  endtask

  task automatic chk_region(input string name, input int loc, input int len);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      loc_read((loc + i) % DEPTH, d);
      if (m_vld[(loc + i) % DEPTH]) chk64(name, d, m_buf[(loc + i) % DEPTH]);
    end
  endtask

  task automatic issue(input bit rwn, input logic [31:0] ext, input int loc, input int len,
                       input int stall);
    int k;
    m_rwn = rwn; m_ext = ext; m_loc = loc; m_len = 32'(len); stall_pct = stall;
    done_cnt = 0; gnt_cnt = 0; req_cyc = 0;
    k = 0;
    @(negedge clk);
    while (!cmd_rdy && k < 100) begin @(negedge clk); k++; end
    chk1("cmd_rdy_wait", cmd_rdy, 1'b1);
    cmd_vld = 1'b1; cmd_rwn = rwn; cmd_ext_adr = ext;
    cmd_loc_adr = AW'(loc); cmd_len = 32'(len);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic run_cmd(input bit rwn, input logic [31:0] ext, input int loc, input int len,
                         input int stall);
    int k;
    int base;
    base = int'(ext >> 3);
    issue(rwn, ext, loc, len, stall);
    if (len == 0) begin
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        chk1($sformatf("len0_done_c%0d", c), done, (c == 2));
        chk1($sformatf("len0_rdy_c%0d", c), cmd_rdy, (c == 3));
      end
      chk64("len0_req_cycles", 64'(req_cyc), 64'd0);
      chk64("len0_done_count", 64'(done_cnt), 64'd1);
    end else begin
      k = 0;
      do begin @(negedge clk); k++; end while (!done && k < 5000);
      chk1("done_seen", done, 1'b1);
      @(negedge clk);
      chk1("done_one_cycle", done, 1'b0);
      chk1("rdy_after_done", cmd_rdy, 1'b1);
      chk64("gnt_count", 64'(gnt_cnt), 64'd1);
      chk64("done_count", 64'(done_cnt), 64'd1);
      for (int i = 0; i < len; i++) begin
        if (rwn) begin
          m_buf[(loc + i) % DEPTH] = ddr[(base + i) % DDR_W];
          m_vld[(loc + i) % DEPTH] = 1'b1;
        end else begin
          chk64("store_ddr", ddr[(base + i) % DDR_W], m_buf[(loc + i) % DEPTH]);
        end
      end
    end
  endtask

  initial begin : main
    logic [63:0] d;
    int k;
    cmd_vld = 1'b0; cmd_rwn = 1'b0; cmd_ext_adr = '0; cmd_loc_adr = '0; cmd_len = '0;
    loc_en = 1'b0; loc_we = 1'b0; loc_adr = '0; loc_wdt = '0;
    m_rwn = 1'b1; m_ext = '0; m_len = '0; m_loc = 0; stall_pct = 0;
    gnt_cnt = 0; done_cnt = 0; req_cyc = 0;
    for (int i = 0; i < DDR_W; i++) ddr[i] = ddr_pat(i);
    for (int i = 0; i < DEPTH; i++) begin m_buf[i] = '0; m_vld[i] = 1'b0; end

    rstn = 1'b1;
    #3 rstn = 1'b0;
    #1;
    chk1("rst_cmd_rdy", cmd_rdy, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_npc_req", npc_req, 1'b0);
    chk64("rst_npc_len", 64'(npc_len), 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    loc_write(32'h200, 64'h0123_4567_89AB_CDEF, 1'b1);
    for (int i = 16'h10; i <= 16'h13B; i++) loc_write(i, loc_pat(i), 1'b1);

    // Zero-length command: no request, done two cycles after accept.
    run_cmd(1'b1, 32'h0000_4000, 5, 0, 0);

    // Load 4 words with random stalls.
    run_cmd(1'b1, 32'h0000_1000, 0, 4, 40);
    chk_region("load4_buf", 0, 4);
    loc_read(0, d);
    chk64("load4_buf0_lit", d, 64'hDDD0_0200_1234_0200);
    loc_read(3, d);
    chk64("load4_buf3_lit", d, 64'hDDD0_0203_1234_0203);

    // Store 300 words back-to-back, with a local write attempted mid-transfer.
    fork
      run_cmd(1'b0, 32'h0000_2000, 16'h10, 300, 0);
      begin
        repeat (20) @(posedge clk);
        loc_write(32'h200, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
      end
    join
    chk64("store_ddr_first_lit", ddr[32'h400], 64'hB0B0_0010_C0C0_0010);
    chk64("store_ddr_last_lit", ddr[32'h52B], 64'hB0B0_013B_C0C0_013B);
    loc_read(32'h200, d);
    chk64("busy_write_ignored", d, 64'h0123_4567_89AB_CDEF);

    // Pointer wrap at the top of the buffer.
    run_cmd(1'b1, 32'h0000_3000, DEPTH - 2, 4, 25);
    chk_region("wrap_buf", DEPTH - 2, 4);
    loc_read(DEPTH - 1, d);
    chk64("wrap_top_lit", d, 64'hDDD0_0601_1234_0601);
    loc_read(0, d);
    chk64("wrap_zero_lit", d, 64'hDDD0_0602_1234_0602);

    // Asynchronous reset in the middle of a load, then a fresh load.
    issue(1'b1, 32'h0000_1800, 32'h300, 16, 30);
    k = 0;
    while (!(npm_active && npm_beat >= 3) && k < 500) begin @(posedge clk); #1; k++; end
    chk1("midrst_reached_xfer", (npm_active && npm_beat >= 3), 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk1("midrst_cmd_rdy", cmd_rdy, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_npc_req", npc_req, 1'b0);
    chk1("midrst_npc_rwn", npc_rwn, 1'b0);
    chk64("midrst_npc_adr", 64'(npc_adr), 64'd0);
    chk64("midrst_npc_len", 64'(npc_len), 64'd0);
    chk64("midrst_npc_wdt", npc_wdt, 64'd0);
    for (int i = 0; i < 16; i++) m_vld[32'h300 + i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    run_cmd(1'b1, 32'h0000_1900, 32'h300, 5, 30);
    chk_region("after_rst_buf", 32'h300, 5);
    loc_read(32'h300, d);
    chk64("after_rst_lit", d, 64'hDDD0_0320_1234_0320);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
